ofm_send_ctrl: RTL and testbench
================================

// Module: ofm_send_ctrl
// PURPOSE
//  Reads one output-feature-map tile from the OFM buffer over the address window
//  [ofm_addr_start, ofm_addr_end) produced by the global parameter generator.
//  Streams the words out on a valid/ready master port, one word per address, in
//  ascending address order. Absorbs the buffer read latency without losing data
//  under backpressure. Sits between the OFM BRAM read port and the DMA/output stream.
// PARAMETERS
//  FM_ADDR_BIT  12  OFM buffer address width
//  DATA_WIDTH   64  OFM word width
//  RD_LATENCY   2   BRAM read latency in cycles (>=1)
// PORTS
//  clk          in   1            clock
//  rst          in   1            async reset, active high
//  start        in   1            start pulse; sampled only in IDLE
//  addr_start   in   FM_ADDR_BIT  first address, inclusive; sampled with start
//  addr_end     in   FM_ADDR_BIT  end address, exclusive; sampled with start
//  busy         out  1            high from accepted start until done
//  done         out  1            one-cycle pulse at transfer end
//  ram_rd_en    out  1            BRAM read enable
//  ram_rd_addr  out  FM_ADDR_BIT  BRAM read address
//  ram_rd_data  in   DATA_WIDTH   BRAM data; valid RD_LATENCY cycles after ram_rd_en
//  m_valid      out  1            stream valid
//  m_ready      in   1            stream ready
//  m_data       out  DATA_WIDTH   stream data
//  m_last       out  1            high on the beat for address addr_end-1
// BEHAVIOUR
//  - Reset: every output 0, FSM in IDLE, skid FIFO and in-flight tracking cleared.
//    Reset mid-transfer aborts at once. m_valid falls asynchronously. No done pulse.
//  - FSM states: IDLE, READ, DRAIN, FIN.
//    IDLE->READ on start when addr_end>addr_start. IDLE->FIN on start when
//    addr_end<=addr_start: zero length, no reads, no beats.
//    READ->DRAIN the cycle the read for addr_end-1 issues.
//    DRAIN->FIN on the handshake of the m_last beat. FIN->IDLE unconditionally.
//  - done=1 only in FIN (exactly one cycle). busy=1 in READ/DRAIN.
//    start while busy is ignored.
//  - Credit rule: localparam FIFO_DEPTH=RD_LATENCY+2.
//    Issue a read only if (fifo_count+in_flight)<FIFO_DEPTH.
//    The FIFO therefore never overflows. Reads are issued in ascending address order.
//  - In-flight tracking: RD_LATENCY-deep valid shift register; its output writes
//    ram_rd_data into the FIFO. The tag bit travels with the data as m_last.
//  - FIFO is first-word-fall-through: a word written at cycle t is presented at t+1.
//  - Latency: start accepted at cycle 0 -> ram_rd_en at cycle 1 -> first m_valid at
//    cycle RD_LATENCY+2. With m_ready=1 the block sustains 1 beat/cycle.
//  - Stream rules: m_data and m_last hold stable while m_valid & !m_ready.
//    m_valid never drops without a handshake.
//  - Address arithmetic is FM_ADDR_BIT wide. addr_end=2^FM_ADDR_BIT is not
//    representable and is not used. Compare uses read_addr==addr_end-1.
// CONFIGURATION
//  OFM_SEND_BEAT_CNT_EN defined:
//    adds output beat_cnt [FM_ADDR_BIT:0]. Cleared at accepted start and by rst.
//    Increments on each m_valid&m_ready. Holds its value after done.
//  Not defined: port and counter are absent; behaviour is otherwise identical.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE/READ/DRAIN/FIN, 2 bits) and the
//    FIFO_DEPTH derivation, so the testbench uses the same values.
//  - One sub-module: ofm_skid_fifo. Synchronous FWFT FIFO, DATA_WIDTH+1 bits wide,
//    FIFO_DEPTH deep, exposes count. Its async rst clears pointers.
// TESTING
//  1. rst, start addr_start=16 addr_end=64, m_ready=1, BRAM data=addr
//     -> 48 beats, data 16..63, m_last only on 63, done pulse 1 cycle after last.
//  2. addr_start=0 addr_end=224, m_ready toggling 1/0 every cycle
//     -> 224 beats, no loss or duplication, data stable while stalled.
//  3. m_ready=0 for 20 cycles after start (0..32)
//     -> at most FIFO_DEPTH reads issued, then resume in order with no gaps.
//  4. addr_start=30 addr_end=30, then addr_start=40 addr_end=12
//     -> done one cycle after each start; no ram_rd_en, no m_valid.
//  5. rst asserted at beat 10 of a 0..100 transfer
//     -> m_valid, busy, ram_rd_en all 0 at once, no done.
//     New start 0..4 after release -> 4 clean beats.
//  6. Second start pulsed while busy -> ignored.
//     With OFM_SEND_BEAT_CNT_EN defined, beat_cnt = 48 after scenario 1.

Source files
------------

// File: rtl/ofm_send_ctrl_pkg.sv
// Shared definitions for the OFM send controller: FSM state encoding and skid FIFO sizing.
package ofm_send_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // One slot per read in flight plus two, so a full pipeline keeps streaming under ready=1.
  function automatic int fifo_depth(input int rd_latency);
    return rd_latency + 2;
  endfunction

endpackage

// File: rtl/ofm_skid_fifo.sv
// First-word-fall-through skid FIFO: a word written in cycle t is presented in cycle t+1.
module ofm_skid_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_rd;

  assign valid   = (count != '0);
  assign do_rd   = rd_en && valid;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({wr_en, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ofm_send_ctrl.sv
// Streams one OFM tile [addr_start, addr_end) from the BRAM read port onto a valid/ready port.
// Optional macro OFM_SEND_BEAT_CNT_EN adds the beat_cnt output.
module ofm_send_ctrl
  import ofm_send_ctrl_pkg::*;
#(
  parameter int FM_ADDR_BIT = 12,
  parameter int DATA_WIDTH  = 64,
  parameter int RD_LATENCY  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [FM_ADDR_BIT-1:0] addr_start,
  input  logic [FM_ADDR_BIT-1:0] addr_end,
  output logic                   busy,
  output logic                   done,
  output logic                   ram_rd_en,
  output logic [FM_ADDR_BIT-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]  ram_rd_data,
  output logic                   m_valid,
  input  logic                   m_ready,
`ifdef OFM_SEND_BEAT_CNT_EN
  output logic [FM_ADDR_BIT:0]   beat_cnt,
`endif
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_last
);

  localparam int FIFO_DEPTH = fifo_depth(RD_LATENCY);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  state_t                 state, state_nxt;
  logic [FM_ADDR_BIT-1:0] read_addr;
  logic [FM_ADDR_BIT-1:0] last_addr;
  logic [RD_LATENCY-1:0]  vld_sr;
  logic [RD_LATENCY-1:0]  tag_sr;
  logic [CNT_W-1:0]       fifo_count;
  logic [DATA_WIDTH:0]    fifo_rd_data;
  logic                   fifo_valid;
  logic                   is_last_rd;
  logic                   issue;
  logic                   hs;
  int                     occupancy;

  assign is_last_rd = (read_addr == last_addr);
  assign hs         = fifo_valid && m_ready;

  // Credit check counts both buffered words and reads still inside the BRAM pipeline.
  always_comb begin
    occupancy = int'(fifo_count);
    for (int i = 0; i < RD_LATENCY; i++) begin
      occupancy = occupancy + int'(vld_sr[i]);
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (addr_end <= addr_start) ? ST_FIN : ST_READ;
      end
      ST_READ: begin
        if (occupancy < FIFO_DEPTH) begin
          issue = 1'b1;
          if (is_last_rd) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (hs && fifo_rd_data[DATA_WIDTH]) state_nxt = ST_FIN;
      end
      ST_FIN: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy        = (state == ST_READ) || (state == ST_DRAIN);
  assign done        = (state == ST_FIN);
  assign ram_rd_en   = issue;
  assign ram_rd_addr = read_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      read_addr <= '0;
      last_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        read_addr <= addr_start;
        last_addr <= addr_end - FM_ADDR_BIT'(1);
      end else if (issue) begin
        read_addr <= read_addr + FM_ADDR_BIT'(1);
      end
    end
  end

  // The last-beat tag rides alongside each read so m_last lines up with the returning data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr <= '0;
      tag_sr <= '0;
    end else begin
      vld_sr[0] <= issue;
      tag_sr[0] <= issue && is_last_rd;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        tag_sr[i] <= tag_sr[i-1];
      end
    end
  end

  ofm_skid_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_skid_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (vld_sr[RD_LATENCY-1]),
    .wr_data ({tag_sr[RD_LATENCY-1], ram_rd_data}),
    .rd_en   (hs),
    .rd_data (fifo_rd_data),
    .valid   (fifo_valid),
    .count   (fifo_count)
  );

  assign m_valid = fifo_valid;
  assign m_data  = fifo_valid ? fifo_rd_data[DATA_WIDTH-1:0] : '0;
  assign m_last  = fifo_valid && fifo_rd_data[DATA_WIDTH];

`ifdef OFM_SEND_BEAT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (state == ST_IDLE && start) begin
      beat_cnt <= '0;
    end else if (hs) begin
      beat_cnt <= beat_cnt + (FM_ADDR_BIT + 1)'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ofm_send_ctrl.sv
// Directed testbench for ofm_send_ctrl; BRAM model returns the read address as data.
// Optional macro OFM_SEND_BEAT_CNT_EN enables the beat_cnt checks.
module tb_ofm_send_ctrl;
  import ofm_send_ctrl_pkg::*;

  localparam int FM_ADDR_BIT = 12;
  localparam int DATA_WIDTH  = 64;
  localparam int RD_LATENCY  = 2;
  localparam int FIFO_DEPTH  = 4;

  logic                   clk;
  logic                   rst;
  logic                   start;
  logic [FM_ADDR_BIT-1:0] addr_start;
  logic [FM_ADDR_BIT-1:0] addr_end;
  logic                   busy;
  logic                   done;
  logic                   ram_rd_en;
  logic [FM_ADDR_BIT-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0]  ram_rd_data;
  logic                   m_valid;
  logic                   m_ready;
  logic [DATA_WIDTH-1:0]  m_data;
  logic                   m_last;
`ifdef OFM_SEND_BEAT_CNT_EN
  logic [FM_ADDR_BIT:0]   beat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [DATA_WIDTH-1:0] beat_data[$];
  logic                  beat_last[$];
  int                    beat_k[$];
  int                    first_rden_k, first_valid_k, done_k, done_cnt, rden_stall, unstable;
  logic                  busy_at1;

  ofm_send_ctrl #(
    .FM_ADDR_BIT (FM_ADDR_BIT),
    .DATA_WIDTH  (DATA_WIDTH),
    .RD_LATENCY  (RD_LATENCY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .addr_start  (addr_start),
    .addr_end    (addr_end),
    .busy        (busy),
    .done        (done),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
`ifdef OFM_SEND_BEAT_CNT_EN
    .beat_cnt    (beat_cnt),
`endif
    .m_data      (m_data),
    .m_last      (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [FM_ADDR_BIT-1:0] addr_p1, addr_p2;
  always @(posedge clk) begin
    addr_p1 <= ram_rd_addr;
    addr_p2 <= addr_p1;
  end
  assign ram_rd_data = {{(DATA_WIDTH-FM_ADDR_BIT){1'b0}}, addr_p2};

  // Collects one transfer's observations; ready is chosen for cycle k before the handshake is sampled.
  task automatic run_xfer(input int a_s, input int a_e, input int mode, input int stall,
                          input int second_k, input int budget);
    logic                  prev_stall;
    logic [DATA_WIDTH-1:0] prev_data;
    logic                  prev_last;
    beat_data.delete(); beat_last.delete(); beat_k.delete();
    first_rden_k = -1; first_valid_k = -1; done_k = -1; done_cnt = 0;
    rden_stall = 0; unstable = 0; busy_at1 = 1'b0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    @(negedge clk);
    start = 1'b1;
    addr_start = FM_ADDR_BIT'(a_s);
    addr_end = FM_ADDR_BIT'(a_e);
    m_ready = (mode == 2) ? 1'b0 : 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      start = (k == second_k);
      if (k == second_k) begin
        addr_start = 12'd500;
        addr_end = 12'd600;
      end
      case (mode)
        1: m_ready = !m_ready;
        2: m_ready = (k >= stall);
        default: m_ready = 1'b1;
      endcase
      if (k == 1) busy_at1 = busy;
      if (ram_rd_en) begin
        if (first_rden_k < 0) first_rden_k = k;
        if (mode == 2 && k <= stall) rden_stall++;
      end
      if (m_valid && first_valid_k < 0) first_valid_k = k;
      if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) unstable++;
      if (m_valid && m_ready) begin
        beat_data.push_back(m_data);
        beat_last.push_back(m_last);
        beat_k.push_back(k);
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && k >= done_k + 3) break;
    end
    start = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; addr_start = '0; addr_end = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid: got %0b expected 0", m_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
    checks++; if (ram_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en: got %0b expected 0", ram_rd_en); end
    checks++; if (ram_rd_addr !== '0) begin errors++; $display("[TB] FAIL reset_rd_addr: got %0d expected 0", ram_rd_addr); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_last: got %0b expected 0", m_last); end
    checks++; if (m_data !== '0) begin errors++; $display("[TB] FAIL reset_m_data: got %0h expected 0", m_data); end
`ifdef OFM_SEND_BEAT_CNT_EN
    checks++; if (beat_cnt !== '0) begin errors++; $display("[TB] FAIL reset_beat_cnt: got %0d expected 0", beat_cnt); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int gaps;
    int n;
    int last_k;
    run_xfer(16, 64, 0, 0, -1, 300);
    n = beat_data.size();
    checks++; if (n != 48) begin errors++; $display("[TB] FAIL basic_beats: got %0d expected 48", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (beat_data[i] !== DATA_WIDTH'(16 + i)) begin errors++; $display("[TB] FAIL basic_data[%0d]: got %0d expected %0d", i, beat_data[i], 16 + i); end
      checks++; if (beat_last[i] !== (i == 47)) begin errors++; $display("[TB] FAIL basic_last[%0d]: got %0b expected %0b", i, beat_last[i], (i == 47)); end
    end
    checks++; if (first_rden_k != 1) begin errors++; $display("[TB] FAIL basic_rden_lat: got %0d expected 1", first_rden_k); end
    checks++; if (first_valid_k != RD_LATENCY + 2) begin errors++; $display("[TB] FAIL basic_valid_lat: got %0d expected %0d", first_valid_k, RD_LATENCY + 2); end
    checks++; if (busy_at1 !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy: got %0b expected 1", busy_at1); end
    gaps = 0;
    for (int i = 1; i < n; i++) if (beat_k[i] != beat_k[i-1] + 1) gaps++;
    checks++; if (gaps != 0) begin errors++; $display("[TB] FAIL basic_gaps: got %0d expected 0", gaps); end
    last_k = (n > 0) ? beat_k[n-1] : -99;
    checks++; if (done_k != last_k + 1) begin errors++; $display("[TB] FAIL basic_done_cycle: got %0d expected %0d", done_k, last_k + 1); end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL basic_done_cnt: got %0d expected 1", done_cnt); end
`ifdef OFM_SEND_BEAT_CNT_EN
    checks++; if (beat_cnt !== 13'd48) begin errors++; $display("[TB] FAIL basic_beat_cnt: got %0d expected 48", beat_cnt); end
`endif
  endtask

  task automatic test_backpressure;
    int n;
    int bad;
    run_xfer(0, 224, 1, 0, -1, 1500);
    n = beat_data.size();
    checks++; if (n != 224) begin errors++; $display("[TB] FAIL bp_beats: got %0d expected 224", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (beat_data[i] !== DATA_WIDTH'(i)) begin errors++; $display("[TB] FAIL bp_data[%0d]: got %0d expected %0d", i, beat_data[i], i); end
    end
    bad = 0;
    for (int i = 0; i < n; i++) if (beat_last[i] !== (i == 223)) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL bp_last: got %0d wrong flags expected 0", bad); end
    checks++; if (unstable != 0) begin errors++; $display("[TB] FAIL bp_stable: got %0d changes expected 0", unstable); end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL bp_done_cnt: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_stall;
    int n;
    int gaps;
    run_xfer(0, 32, 2, 20, -1, 400);
    n = beat_data.size();
    checks++; if (rden_stall < 1 || rden_stall > FIFO_DEPTH) begin errors++; $display("[TB] FAIL stall_reads: got %0d expected 1..%0d", rden_stall, FIFO_DEPTH); end
    checks++; if (n != 32) begin errors++; $display("[TB] FAIL stall_beats: got %0d expected 32", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (beat_data[i] !== DATA_WIDTH'(i)) begin errors++; $display("[TB] FAIL stall_data[%0d]: got %0d expected %0d", i, beat_data[i], i); end
    end
    checks++; if ((n > 0 ? beat_k[0] : -1) != 20) begin errors++; $display("[TB] FAIL stall_first_beat: got %0d expected 20", n > 0 ? beat_k[0] : -1); end
    gaps = 0;
    for (int i = 1; i < n; i++) if (beat_k[i] != beat_k[i-1] + 1) gaps++;
    checks++; if (gaps != 0) begin errors++; $display("[TB] FAIL stall_gaps: got %0d expected 0", gaps); end
    checks++; if (unstable != 0) begin errors++; $display("[TB] FAIL stall_stable: got %0d changes expected 0", unstable); end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL stall_done_cnt: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_zero_len;
    int vec_s[2] = '{30, 40};
    int vec_e[2] = '{30, 12};
    for (int v = 0; v < 2; v++) begin
      run_xfer(vec_s[v], vec_e[v], 0, 0, -1, 20);
      checks++; if (done_k != 1) begin errors++; $display("[TB] FAIL zero%0d_done_cycle: got %0d expected 1", v, done_k); end
      checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL zero%0d_done_cnt: got %0d expected 1", v, done_cnt); end
      checks++; if (first_rden_k != -1) begin errors++; $display("[TB] FAIL zero%0d_rden: got %0d expected -1", v, first_rden_k); end
      checks++; if (first_valid_k != -1) begin errors++; $display("[TB] FAIL zero%0d_valid: got %0d expected -1", v, first_valid_k); end
      checks++; if (busy_at1 !== 1'b0) begin errors++; $display("[TB] FAIL zero%0d_busy: got %0b expected 0", v, busy_at1); end
    end
  endtask

  task automatic test_reset_mid;
    int nb;
    int dn;
    int n;
    nb = 0;
    @(negedge clk);
    start = 1'b1; addr_start = 12'd0; addr_end = 12'd100; m_ready = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (m_valid && m_ready) nb++;
      if (nb == 10) break;
    end
    checks++; if (nb != 10) begin errors++; $display("[TB] FAIL rstmid_reach: got %0d beats expected 10", nb); end
    rst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_m_valid: got %0b expected 0", m_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %0b expected 0", busy); end
    checks++; if (ram_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_rd_en: got %0b expected 0", ram_rd_en); end
    dn = 0;
    if (done) dn++;
    repeat (3) begin
      @(negedge clk);
      if (done) dn++;
    end
    checks++; if (dn != 0) begin errors++; $display("[TB] FAIL rstmid_no_done: got %0d expected 0", dn); end
    rst = 1'b0;
    run_xfer(0, 4, 0, 0, -1, 50);
    n = beat_data.size();
    checks++; if (n != 4) begin errors++; $display("[TB] FAIL rstmid_beats: got %0d expected 4", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (beat_data[i] !== DATA_WIDTH'(i)) begin errors++; $display("[TB] FAIL rstmid_data[%0d]: got %0d expected %0d", i, beat_data[i], i); end
      checks++; if (beat_last[i] !== (i == 3)) begin errors++; $display("[TB] FAIL rstmid_last[%0d]: got %0b expected %0b", i, beat_last[i], (i == 3)); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL rstmid_done_cnt: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_back_to_back;
    int n;
    int bad;
    run_xfer(16, 64, 0, 0, 5, 300);
    n = beat_data.size();
    checks++; if (n != 48) begin errors++; $display("[TB] FAIL b2b_beats: got %0d expected 48", n); end
    bad = 0;
    for (int i = 0; i < n; i++) if (beat_data[i] !== DATA_WIDTH'(16 + i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL b2b_data: got %0d wrong words expected 0", bad); end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL b2b_done_cnt: got %0d expected 1", done_cnt); end
`ifdef OFM_SEND_BEAT_CNT_EN
    checks++; if (beat_cnt !== 13'd48) begin errors++; $display("[TB] FAIL b2b_beat_cnt: got %0d expected 48", beat_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stall();
    test_zero_len();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
